// File: rtl/tt_uart_rx.sv
// ============================================================================
// Module      : tt_uart_rx
// Description : 8N1 UART receiver with input synchroniser, mid-bit sampling
//               and a valid/ready byte interface. Optional even parity bit
//               when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tt_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    logic rxs;
    logic cnt_last;
    logic cnt_half;

    // Synchroniser presets to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_half = (cnt_q == CNT_HALF);

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic perr_q, perr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        // A pending accept is applied first; a byte completing in the same
        // cycle may then overwrite the holding register.
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_half) begin
                    cnt_d   = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    par_bad_d = rxs ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif

            S_STOP: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    if (!rxs) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        state_d = S_IDLE;
                        if (valid_q && !rx_ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                end
            end

            // A line held low after a framing error must not re-trigger.
            S_BREAK: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_uart_rx.sv
// ============================================================================
// Module      : tb_tt_uart_rx
// Description : Directed self-checking bench for tt_uart_rx (16 clk/bit, 8N1).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tt_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
    logic par_flip = 1'b0;
`else
    localparam int PB = 0;
`endif
    // Cycle offset from driving the start bit to the first output change:
    // two synchroniser cycles plus the t0+153 completion latency.
    localparam int DONE = 155 + 16 * PB;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          rx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    tt_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle.
    logic          prev_valid = 1'b0;
    logic [DB-1:0] rise_data  = '0;
    int n_rise = 0, rise_cyc = -1, fall_cyc = -1;
    int n_ferr = 0, ferr_cyc = -1;
    int n_ovr  = 0, ovr_cyc  = -1;
    int n_perr = 0, perr_cyc = -1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            n_rise++;
            rise_cyc  = cyc;
            rise_data = rx_data;
        end
        if (!rx_valid && prev_valid) fall_cyc = cyc;
        if (frame_err)  begin n_ferr++; ferr_cyc = cyc; end
        if (overrun)    begin n_ovr++;  ovr_cyc  = cyc; end
        if (parity_err) begin n_perr++; perr_cyc = cyc; end
        prev_valid = rx_valid;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) tick();
    endtask

    int c0;

    task automatic send_byte(input logic [DB-1:0] d, input logic stop);
        c0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop);
        rx_in = 1'b1;
    endtask

    int r0, f0, o0, c0a;
    logic [DB-1:0] frame5a;

    initial begin
        rst      = 1'b1;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        tick();

        chk("reset_valid",  rx_valid,   0);
        chk("reset_data",   rx_data,    0);
        chk("reset_busy",   busy,       0);
        chk("reset_ferr",   frame_err,  0);
        chk("reset_ovr",    overrun,    0);
        chk("reset_perr",   parity_err, 0);
        idle(5);

        // 1: 0xA5 with consumer always ready
        rx_ready = 1'b1;
        r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
        send_byte(8'hA5, 1'b1);
        idle(20);
        chk("a5_count", n_rise - r0, 1);
        chk("a5_rise",  rise_cyc,  c0 + DONE);
        chk("a5_data",  rise_data, 8'hA5);
        chk("a5_fall",  fall_cyc,  c0 + DONE + 1);
        chk("a5_ferr",  n_ferr - f0, 0);
        chk("a5_ovr",   n_ovr - o0,  0);

        // 2: 4-cycle low glitch is a false start
        r0 = n_rise;
        rx_in = 1'b0;
        c0 = cyc;
        idle(4);
        rx_in = 1'b1;
        idle(6);
        chk("glitch_busy_t8", busy, 1);
        tick();
        chk("glitch_busy_t9", busy, 0);
        idle(30);
        chk("glitch_novalid", n_rise - r0, 0);

        // 3: bad stop bit, then a clean frame
        r0 = n_rise; f0 = n_ferr;
        send_byte(8'h3C, 1'b0);
        idle(30);
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_cyc",   ferr_cyc,    c0 + DONE);
        chk("ferr_novalid", n_rise - r0, 0);
        send_byte(8'h3C, 1'b1);
        idle(20);
        chk("after_ferr_count", n_rise - r0, 1);
        chk("after_ferr_data",  rise_data,   8'h3C);
        chk("after_ferr_once",  n_ferr - f0, 1);

        // 4a: back-to-back with consumer stalled -> overrun
        rx_ready = 1'b0;
        r0 = n_rise; o0 = n_ovr;
        send_byte(8'h11, 1'b1);
        c0a = c0;
        send_byte(8'h22, 1'b1);
        idle(5);
        chk("ovr_valid", rx_valid,    1);
        chk("ovr_data",  rx_data,     8'h11);
        chk("ovr_count", n_ovr - o0,  1);
        chk("ovr_cyc",   ovr_cyc,     c0 + DONE);
        chk("ovr_first", rise_cyc,    c0a + DONE);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("ovr_accept", rx_valid, 0);

        // 4b: accept coincides with completion of the next byte
        o0 = n_ovr;
        send_byte(8'h11, 1'b1);
        fork
            send_byte(8'h22, 1'b1);
            begin
                idle(DONE - 1);
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
                chk("simul_valid", rx_valid, 1);
                chk("simul_data",  rx_data,  8'h22);
            end
        join
        idle(5);
        chk("simul_noovr", n_ovr - o0, 0);
        rx_ready = 1'b1;
        tick();
        chk("simul_accept", rx_valid, 0);

        // 5: reset during data bit 4 of 0x5A, line then left idle
        frame5a = 8'h5A;
        r0 = n_rise;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(frame5a[i]);
        rx_in = frame5a[4];
        idle(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_data",  rx_data,  0);
        chk("rst_mid_busy",  busy,     0);
        rx_in = 1'b1;
        idle(40);
        chk("rst_mid_nobyte", n_rise - r0, 0);
        send_byte(8'h5A, 1'b1);
        idle(20);
        chk("rst_next_count", n_rise - r0, 1);
        chk("rst_next_data",  rise_data,   8'h5A);

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch discards the byte, then a correct parity frame
        r0 = n_rise;
        par_flip = 1'b1;
        send_byte(8'h07, 1'b1);
        idle(20);
        chk("perr_count", n_perr,      1);
        chk("perr_cyc",   perr_cyc,    c0 + DONE);
        chk("perr_novalid", n_rise - r0, 0);
        par_flip = 1'b0;
        send_byte(8'h07, 1'b1);
        idle(20);
        chk("par_ok_data", rise_data, 8'h07);
        chk("par_ok_once", n_perr,    1);
`else
        chk("perr_never", n_perr, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
